// File: rtl/fetch_queue_pkg.sv
// Shared widths and the queued fetch entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Program counter increment; wraps silently at the top of the program space.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, downstream handshake and redirect request.
interface fetch_queue_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Small synchronous FIFO of fetch entries with flush; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Qualify requests: pop needs data, push needs room unless the head leaves this edge.
  always_comb begin
    pop_ok_s  = pop && (count_r != CNT_W'(0));
    push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads imem one word per cycle and buffers
// {pc, instr} pairs for the downstream stage; redirects flush the queue and reload the PC.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.master bus
);

  logic [PC_W-1:0]          fetch_pc_r;
  logic                     push_s;
  logic                     pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [$clog2(DEPTH):0]   fifo_count_s;
  fetch_entry_t             wr_entry_s;
  fetch_entry_t             head_s;

  assign bus.imem_addr = fetch_pc_r;

  // Handshake and fetch control; a redirect suppresses the push of the stale word.
  always_comb begin
    pop_s      = !fifo_empty_s && bus.out_ready;
    wr_entry_s = '{pc: fetch_pc_r, instr: bus.imem_rdata};
    if (bus.redirect_valid) begin
      push_s = 1'b0;
    end else begin
      push_s = !fifo_full_s || pop_s;
    end
  end

  // Program counter: redirect target, else advance on every accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= bus.redirect_pc;
    end else if (push_s) begin
      fetch_pc_r <= next_pc(fetch_pc_r);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (bus.redirect_valid),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Head presentation straight from queue state; zeros rather than stale data when empty.
  always_comb begin
    if (fifo_count_s == '0) begin
      bus.out_valid = 1'b0;
      bus.out_pc    = '0;
      bus.out_instr = '0;
    end else begin
      bus.out_valid = 1'b1;
      bus.out_pc    = head_s.pc;
      bus.out_instr = head_s.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; imem model returns addr+100.
module tb_fetch_queue;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = 32'(bus.imem_addr) + 32'd100;

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 5'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %0d want 0", bus.out_instr); end
    n_checks++; if (bus.imem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.out_ready = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_empty: got %0b want 0", bus.out_valid); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d: got %0b want 1", k, bus.out_valid); end
      n_checks++; if (bus.out_pc !== 5'(k)) begin n_fail++; $display("FAIL stream_pc: got %0d want %0d", bus.out_pc, k); end
      n_checks++; if (bus.out_instr !== 32'(k) + 32'd100) begin n_fail++; $display("FAIL stream_instr: got %0d want %0d", bus.out_instr, k + 100); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (bus.imem_addr !== 5'd2) begin n_fail++; $display("FAIL stall_addr: got %0d want 2", bus.imem_addr); end
    n_checks++; if (dut.u_fifo.count !== 2'd2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", dut.u_fifo.count); end
    n_checks++; if (bus.out_pc !== 5'd0) begin n_fail++; $display("FAIL stall_pc: got %0d want 0", bus.out_pc); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_pc !== 5'(k)) begin n_fail++; $display("FAIL release_pc: got %0d want %0d", bus.out_pc, k); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid k=%0d: got %0b want 1", k, bus.out_valid); end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (bus.out_pc !== 5'd3) begin n_fail++; $display("FAIL redir_head: got %0d want 3", bus.out_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 5'd17;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.imem_addr !== 5'd17) begin n_fail++; $display("FAIL redir_addr: got %0d want 17", bus.imem_addr); end
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 5'd17) begin n_fail++; $display("FAIL redir_pc: got %0d want 17", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'd117) begin n_fail++; $display("FAIL redir_instr: got %0d want 117", bus.out_instr); end
    @(posedge clk); #1;
    n_checks++; if (bus.out_pc !== 5'd18) begin n_fail++; $display("FAIL redir_next: got %0d want 18", bus.out_pc); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 5'd30;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble: got %0b want 0", bus.out_valid); end
    exp_pc = 5'd30;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %0d want %0d", bus.out_pc, exp_pc); end
      n_checks++; if (bus.out_instr !== 32'(exp_pc) + 32'd100) begin n_fail++; $display("FAIL wrap_instr: got %0d want %0d", bus.out_instr, exp_pc + 100); end
      exp_pc = exp_pc + 5'd1;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (dut.u_fifo.count !== 2'd2) begin n_fail++; $display("FAIL areset_prefull: got %0d want 2", dut.u_fifo.count); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 5'd0) begin n_fail++; $display("FAIL areset_pc: got %0d want 0", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL areset_instr: got %0d want 0", bus.out_instr); end
    n_checks++; if (bus.imem_addr !== 5'd0) begin n_fail++; $display("FAIL areset_addr: got %0d want 0", bus.imem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 5'd0) begin n_fail++; $display("FAIL restart_pc: got %0d want 0", bus.out_pc); end
  endtask

  task automatic test_random_ready();
    logic [4:0] exp_pc;
    int delivered;
    apply_reset();
    exp_pc = 5'd0;
    delivered = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n_checks++; if (dut.u_fifo.count > 2'd2) begin n_fail++; $display("FAIL rand_count: got %0d want <=2", dut.u_fifo.count); end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        n_checks++; if (bus.out_pc !== exp_pc) begin n_fail++; $display("FAIL rand_pc: got %0d want %0d", bus.out_pc, exp_pc); end
        n_checks++; if (bus.out_instr !== 32'(exp_pc) + 32'd100) begin n_fail++; $display("FAIL rand_instr: got %0d want %0d", bus.out_instr, exp_pc + 100); end
        exp_pc = exp_pc + 5'd1;
        delivered++;
      end
    end
    n_checks++; if (delivered < 20) begin n_fail++; $display("FAIL rand_throughput: got %0d want >=20", delivered); end
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
